// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider for MIPS32 DIV/DIVU.
// A start strobe in IDLE latches operand magnitudes and sign fixups. The block
// then runs 32 one-bit iterations and one result-fixup cycle. Stall covers the
// whole operation, and Quotient/Remainder hold their values until the next
// completed divide.
module seq_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        OP_div,
    input  logic        OP_divu,
    input  logic        Flush,
    input  logic [31:0] Dividend,
    input  logic [31:0] Divisor,
    output logic [31:0] Quotient,
    output logic [31:0] Remainder,
    output logic        Stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        accept;
    logic        load;
    logic        iterate;
    logic        write_back;

    // Operand state latched on accept
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic [31:0] divisor_mag;
    logic [31:0] dividend_orig;

    // Iteration state
    logic [32:0] prem;
    logic [31:0] shift;
    logic [4:0]  count;

    // Combinational helpers
    logic        signed_sel;
    logic [31:0] dividend_mag;
    logic [31:0] divisor_abs;
    logic [33:0] shifted;
    logic [33:0] trial;
    logic        take;

    // A start is only considered in IDLE. Flush vetoes a same-cycle start.
    assign accept = (OP_div | OP_divu) & ~Flush;

    // OP_div has priority, so a double strobe is a signed divide.
    assign signed_sel   = OP_div;
    assign dividend_mag = (signed_sel & Dividend[31]) ? (32'd0 - Dividend) : Dividend;
    assign divisor_abs  = (signed_sel & Divisor[31])  ? (32'd0 - Divisor)  : Divisor;

    // One restoring step: shift the next dividend bit in, then try a subtract.
    // The shifted value is below 2*divisor, so 34 bits keep the sign unambiguous.
    assign shifted = {prem, shift[31]};
    assign trial   = shifted - {2'b00, divisor_mag};
    assign take    = ~trial[33];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = DIVIDE;
            DIVIDE:  if (Flush) state_next = IDLE;
                     else if (count == 5'd31) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath control decoded from the current state. Flush suppresses any
    // further iteration and the result write.
    always_comb begin
        load       = (state == IDLE) & accept;
        iterate    = (state == DIVIDE) & ~Flush;
        write_back = (state == FIXUP) & ~Flush;
    end

    // Busy flag is registered from the next state, so it is glitch-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Stall <= 1'b0;
        end else begin
            Stall <= (state_next != IDLE);
        end
    end

    // Operand capture and one quotient bit per DIVIDE cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            div_zero      <= 1'b0;
            divisor_mag   <= 32'd0;
            dividend_orig <= 32'd0;
            prem          <= 33'd0;
            shift         <= 32'd0;
            count         <= 5'd0;
        end else if (load) begin
            neg_q         <= signed_sel & (Dividend[31] ^ Divisor[31]);
            neg_r         <= signed_sel & Dividend[31];
            div_zero      <= (Divisor == 32'd0);
            divisor_mag   <= divisor_abs;
            dividend_orig <= Dividend;
            prem          <= 33'd0;
            shift         <= dividend_mag;
            count         <= 5'd0;
        end else if (iterate) begin
            prem  <= take ? trial[32:0] : shifted[32:0];
            shift <= {shift[30:0], take};
            count <= count + 5'd1;
        end
    end

    // Result registers: written only in an unflushed FIXUP, held otherwise.
    // The sign of the remainder follows the dividend, as MIPS requires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Quotient  <= 32'd0;
            Remainder <= 32'd0;
        end else if (write_back) begin
            if (div_zero) begin
                Quotient  <= 32'hFFFF_FFFF;
                Remainder <= dividend_orig;
            end else begin
                Quotient  <= neg_q ? (32'd0 - shift) : shift;
                Remainder <= neg_r ? (32'd0 - prem[31:0]) : prem[31:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized divides
// compared against an arithmetic reference model.
module tb_seq_divider;

    logic        clock;
    logic        reset;
    logic        OP_div;
    logic        OP_divu;
    logic        Flush;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        Stall;

    int checks = 0;
    int errors = 0;

    seq_divider dut (
        .clock     (clock),
        .reset     (reset),
        .OP_div    (OP_div),
        .OP_divu   (OP_divu),
        .Flush     (Flush),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Stall     (Stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // MIPS divide semantics from plain arithmetic: truncating division,
    // remainder carries the dividend's sign, x/0 gives all-ones and x.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, lq, lr;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Called at a negedge. mode: 0 DIVU, 1 DIV, 2 both strobes.
    // ev_kind: 0 none, 1 stray OP_div strobe, 2 Flush, 3 async reset,
    // applied in the busy cycle numbered ev_cycle.
    task automatic run_div(input string tag, input int mode,
                           input logic [31:0] a, input logic [31:0] b,
                           input int ev_cycle, input int ev_kind,
                           input int exp_cycles,
                           input logic [31:0] exp_q, input logic [31:0] exp_r);
        int cycles;
        OP_div   = (mode != 0);
        OP_divu  = (mode != 1);
        Dividend = a;
        Divisor  = b;
        @(negedge clock);
        OP_div   = 1'b0;
        OP_divu  = 1'b0;
        Dividend = $urandom;
        Divisor  = $urandom;
        cycles   = 0;
        while (Stall && cycles < 40) begin
            cycles++;
            if (cycles == ev_cycle) begin
                if (ev_kind == 1) begin
                    OP_div   = 1'b1;
                    Dividend = 32'd1000;
                    Divisor  = 32'd10;
                end else if (ev_kind == 2) begin
                    Flush = 1'b1;
                end else if (ev_kind == 3) begin
                    #2 reset = 1'b1;
                    #1;
                    check({tag, " async stall"}, {31'd0, Stall}, 32'd0);
                    check({tag, " async q"}, Quotient, 32'd0);
                    check({tag, " async r"}, Remainder, 32'd0);
                end
            end
            @(negedge clock);
            OP_div  = 1'b0;
            OP_divu = 1'b0;
            Flush   = 1'b0;
            reset   = 1'b0;
        end
        check({tag, " stall cycles"}, cycles, exp_cycles);
        check({tag, " quotient"}, Quotient, exp_q);
        check({tag, " remainder"}, Remainder, exp_r);
        $display("div %-14s mode=%0d a=0x%08h b=0x%08h busy=%0d q=0x%08h r=0x%08h",
                 tag, mode, a, b, cycles, Quotient, Remainder);
    endtask

    initial begin
        logic [63:0] exp_qr;
        logic [31:0] a, b;
        int          mode;

        reset    = 1'b1;
        OP_div   = 1'b0;
        OP_divu  = 1'b0;
        Flush    = 1'b0;
        Dividend = 32'd0;
        Divisor  = 32'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset stall", {31'd0, Stall}, 32'd0);
        check("reset q", Quotient, 32'd0);
        check("reset r", Remainder, 32'd0);

        // Directed cases
        run_div("divu100/7", 0, 32'd100, 32'd7, 0, 0, 33, 32'd14, 32'd2);
        run_div("div-7/2", 1, 32'hFFFF_FFF9, 32'd2, 0, 0, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div7/-2", 1, 32'd7, 32'hFFFF_FFFE, 0, 0, 33, 32'hFFFF_FFFD, 32'd1);
        run_div("div_minint/-1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 33, 32'h8000_0000, 32'd0);
        run_div("divu_by0", 0, 32'h1234_5678, 32'd0, 0, 0, 33, 32'hFFFF_FFFF, 32'h1234_5678);
        run_div("div_by0", 1, 32'h8000_0001, 32'd0, 0, 0, 33, 32'hFFFF_FFFF, 32'h8000_0001);
        run_div("both-7/2", 2, 32'hFFFF_FFF9, 32'd2, 0, 0, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

        // Ignored strobe while busy
        run_div("divu9/4", 0, 32'd9, 32'd4, 0, 0, 33, 32'd2, 32'd1);
        run_div("divu50/3+strobe", 0, 32'd50, 32'd3, 10, 1, 33, 32'd16, 32'd2);

        // Flush mid-operation keeps previous results
        run_div("divu9/4", 0, 32'd9, 32'd4, 0, 0, 33, 32'd2, 32'd1);
        run_div("flushed", 0, 32'hFFFF_FFFF, 32'd3, 15, 2, 15, 32'd2, 32'd1);
        run_div("divu20/6", 0, 32'd20, 32'd6, 0, 0, 33, 32'd3, 32'd2);

        // Flush in IDLE blocks a same-cycle start
        OP_divu  = 1'b1;
        Flush    = 1'b1;
        Dividend = 32'd5;
        Divisor  = 32'd1;
        @(negedge clock);
        OP_divu = 1'b0;
        Flush   = 1'b0;
        check("idle flush stall", {31'd0, Stall}, 32'd0);
        check("idle flush q", Quotient, 32'd3);
        $display("idle flush blocked start stall=%0d q=0x%08h", Stall, Quotient);
        repeat (3) @(negedge clock);
        check("hold q", Quotient, 32'd3);
        check("hold r", Remainder, 32'd2);

        // Asynchronous reset mid-operation, then a clean divide
        run_div("div-100/7 rst", 1, 32'hFFFF_FF9C, 32'd7, 20, 3, 20, 32'd0, 32'd0);
        run_div("div-100/7", 1, 32'hFFFF_FF9C, 32'd7, 0, 0, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

        // Randomized divides against the reference model
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                3:       b = a;
                4:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            exp_qr = ref_div(mode != 0, a, b);
            run_div("random", mode, a, b, 0, 0, 33, exp_qr[63:32], exp_qr[31:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative radix-2 restoring divider serving the MIPS32 DIV/DIVU instructions. It is the responder side of the ALU divide handshake. The ALU pulses a start strobe with operands, and this block holds `Stall` high for a fixed 33 cycles. It then presents `Quotient` and `Remainder`, which the HI/LO write path consumes as LO and HI respectively.

## Interface
Parameters:
- none (fixed 32-bit datapath, fixed 32 iterations)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- OP_div  input  1  single-cycle start strobe, signed divide
- OP_divu  input  1  single-cycle start strobe, unsigned divide
- Flush  input  1  abandon the in-flight divide (pipeline exception/flush)
- Dividend  input  32  numerator; sampled only on an accepted start
- Divisor  input  32  denominator; sampled only on an accepted start
- Quotient  output  32  registered quotient of the last completed divide
- Remainder  output  32  registered remainder of the last completed divide
- Stall  output  1  registered busy flag; high from the cycle after an accepted start until results are written

## Operation
- States: IDLE, DIVIDE, FIXUP.
- **Reset values:** state IDLE, `Quotient`=0, `Remainder`=0, `Stall`=0, iteration counter 0.
- **Accept (IDLE only):** a start is accepted when (`OP_div` | `OP_divu`) & ~`Flush`.
  - If both strobes are high, `OP_div` wins and the divide is signed.
  - Strobes seen in DIVIDE or FIXUP are ignored, with no queueing.
- **On accept**, the block latches:
  - sign mode;
  - |Dividend| and |Divisor| (two's-complement magnitude when signed; raw when unsigned), so |0x80000000| = 0x80000000 as an unsigned 32-bit value;
  - negQ = signed & (Dividend[31] ^ Divisor[31]);
  - negR = signed & Dividend[31];
  - divZero = (Divisor == 0);
  - original Dividend, kept for the divide-by-zero result.
- **Accept action:** clear the 33-bit partial remainder, load the shift register with |Dividend|, set counter=0, go to DIVIDE, set `Stall`=1.
- **DIVIDE, one quotient bit per cycle:**
  - shift {partialRem, shiftReg} left 1;
  - trial = partialRem − {1'b0,|Divisor|} (33-bit);
  - if trial ≥ 0, partialRem=trial and shift in 1; else keep partialRem and shift in 0;
  - counter increments; after the 32nd iteration (counter==31 at the edge), go to FIXUP.
- **FIXUP (1 cycle)**, writing the output registers:
  - divZero: `Quotient`=0xFFFFFFFF, `Remainder`=latched Dividend, for both signed and unsigned.
  - Otherwise: `Quotient` = negQ ? −q : q; `Remainder` = negR ? −r : r.
  - Results are truncated toward zero, and the remainder takes the dividend's sign (MIPS semantics).
  - Signed 0x80000000 / −1 yields `Quotient`=0x80000000, `Remainder`=0. No overflow flag is produced.
  - Then go to IDLE and set `Stall`=0.
- **Hold:** `Quotient` and `Remainder` change only in FIXUP or on reset. They hold their values indefinitely in IDLE.
- **Flush** in DIVIDE or FIXUP: next edge goes to IDLE, `Stall`=0, outputs unchanged (the previous results are retained). Flush in IDLE has no effect and blocks a same-cycle start.
- **Reset mid-operation:** immediately returns to the reset values, regardless of clock.

## Timing
- Start sampled at edge N: `Stall`=1 after edge N.
- 32 DIVIDE iterations occur at edges N+1..N+32; FIXUP happens at edge N+33.
- After edge N+33, `Stall`=0 and results are valid, so `Stall` is high for exactly 33 cycles.
- A new start may be accepted at edge N+34 (the first cycle `Stall` is low). Back-to-back divides therefore issue every 34 cycles.
- Start strobes are expected to be a single cycle long. A strobe held high re-triggers whenever the block is IDLE.
- Operand inputs are don't-care except in the accept cycle.
- No combinational path from any input to any output.

## Test plan
- **Unsigned:** DIVU 100/7 at edge N → `Stall` high for exactly 33 cycles; after N+33, Q=14, R=2.
- **Signed, mixed signs:**
  - DIV −7/2 → Q=0xFFFFFFFD, R=0xFFFFFFFF;
  - DIV 7/−2 → Q=0xFFFFFFFD, R=1;
  - DIV 0x80000000/0xFFFFFFFF → Q=0x80000000, R=0.
- **Divide by zero:**
  - DIVU 0x12345678/0 → Q=0xFFFFFFFF, R=0x12345678;
  - DIV 0x80000001/0 → Q=0xFFFFFFFF, R=0x80000001.
- **Ignored strobe:** complete DIVU 9/4 (Q=2, R=1). Start DIVU 50/3 and pulse OP_div with 1000/10 at cycle 10 of it → strobe ignored, completion at N+33 with Q=16, R=2.
- **Flush mid-op:** after DIVU 9/4 completes (Q=2, R=1), start DIVU 0xFFFFFFFF/3 and assert Flush at cycle 15.
  - `Stall` falls the next cycle; Q=2, R=1 are retained.
  - A new DIVU 20/6 accepted next → Q=3, R=2.
- **Async reset mid-op:** start DIV −100/7 and assert reset asynchronously mid-cycle at cycle 20 → `Stall`, Q, R go to 0 without a clock edge.
  - After release, DIV −100/7 → Q=0xFFFFFFF2 (−14), R=0xFFFFFFFE (−2).
